probe_mem_responder: RTL and testbench

In-order read responder that serves the 48-bit-address / 64-bit-data request/response memory port issued by the probe engine's hash-table and linked-list lookup stages. It accepts read requests, reads an on-chip table RAM, and returns responses in request order. Flow control uses the engine's almost-full convention in both directions. A side load port lets the build phase, or a testbench, fill the table before probing.

---
 rtl/probe_mem_responder_pkg.sv | 26 ++
 rtl/probe_mem_responder_resp_fifo.sv | 59 +++++
 rtl/probe_mem_responder.sv | 140 ++++++++++++++
 tb/tb_probe_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_mem_responder_pkg.sv
// Shared constants and address decode for the probe engine's memory responder.
package probe_mem_pkg;

  localparam int ADDR_BITS  = 48;
  localparam int DATA_BITS  = 64;
  localparam int WORD_SHIFT = 3;
  localparam int INDEX_BITS = ADDR_BITS - WORD_SHIFT;
  localparam logic [DATA_BITS-1:0] NULL_PTR = 64'h0;

  typedef struct packed {
    logic                  range_ok;
    logic [INDEX_BITS-1:0] index;
  } addr_info_t;

  // Split a byte address into its word index and a flag that is set only when
  // the address is word-aligned and falls inside a table of 2^addr_w words.
  function automatic addr_info_t decode_addr(input logic [ADDR_BITS-1:0] addr,
                                             input int                   addr_w);
    addr_info_t info;
    info.index    = addr[ADDR_BITS-1:WORD_SHIFT];
    info.range_ok = (addr[WORD_SHIFT-1:0] == '0) &&
                    ((addr >> (addr_w + WORD_SHIFT)) == '0);
    return info;
  endfunction

endpackage

// File: rtl/probe_mem_responder_resp_fifo.sv
// Synchronous first-word-fall-through FIFO holding responses until the
// receiver can take them. Pointers wrap naturally because DEPTH is a power of two.
module resp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = storage[rd_ptr_q];

  // Next pointer and fill-level values; full/empty guards keep state consistent.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr_q] <= push_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/probe_mem_responder.sv
// In-order read responder for the probe engine's table memory port.
// Requests pass S0 (accept + RAM read), S1 (registered RAM data), S2 (FIFO
// write); responses pop from an FWFT FIFO. Optional build macro
// PROBE_MEM_BOUNDS_CHECK_EN turns misaligned or out-of-table addresses into
// null-pointer responses / ignored loads that raise error_out.
module probe_mem_responder
  import probe_mem_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int RESP_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 done,
  output logic                 rq_afull_out,
  input  logic                 rq_vld_in,
  input  logic [ADDR_BITS-1:0] rq_address_in,
  input  logic                 rs_afull_in,
  output logic                 rs_write_en_out,
  output logic [DATA_BITS-1:0] rs_data_out,
  input  logic                 ld_write_en_in,
  input  logic [ADDR_BITS-1:0] ld_address_in,
  input  logic [DATA_BITS-1:0] ld_data_in,
  output logic                 error_out
);

  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam int WORDS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] OCC_FULL  = CNT_W'(RESP_DEPTH);
  localparam logic [CNT_W-1:0] OCC_AFULL = CNT_W'(RESP_DEPTH - AFULL_MARGIN);

  logic [DATA_BITS-1:0] table_mem [WORDS];
  logic [DATA_BITS-1:0] ram_rd_data;

  addr_info_t        rd_info, ld_info;
  logic [ADDR_W-1:0] rd_idx, ld_idx;
  logic              rd_ok, ld_ok;
  logic              overflow, accept, rd_fire, ld_fire, pop;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_null_q, s1_null_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [DATA_BITS-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0]     occ_q, occ_d;
  logic                 afull_q, afull_d;
  logic                 error_q, error_d;

  logic                 fifo_empty, fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 unused_status;

  // Address decode, acceptance, and the pop decision for this cycle.
  always_comb begin
    rd_info = decode_addr(rq_address_in, ADDR_W);
    ld_info = decode_addr(ld_address_in, ADDR_W);
    rd_idx  = rd_info.index[ADDR_W-1:0];
    ld_idx  = ld_info.index[ADDR_W-1:0];
`ifdef PROBE_MEM_BOUNDS_CHECK_EN
    rd_ok   = rd_info.range_ok;
    ld_ok   = ld_info.range_ok;
`else
    rd_ok   = 1'b1;
    ld_ok   = 1'b1;
`endif
    overflow = rq_vld_in && (occ_q == OCC_FULL);
    accept   = rq_vld_in && !overflow;
    rd_fire  = accept && rd_ok;
    ld_fire  = ld_write_en_in && ld_ok;
    pop      = !fifo_empty && !rs_afull_in;
  end

  // Table RAM: a same-cycle read of the word being loaded sees the old value.
  always_ff @(posedge clk) begin
    if (ld_fire) table_mem[ld_idx] <= ld_data_in;
    if (rd_fire) ram_rd_data <= table_mem[rd_idx];
  end

  // Next-state for pipeline valids, occupancy, afull and the sticky error.
  always_comb begin
    s1_valid_d = accept;
    s1_null_d  = accept && !rd_ok;
    s2_valid_d = s1_valid_q;
    s2_data_d  = s1_null_q ? NULL_PTR : ram_rd_data;
    occ_d      = occ_q + CNT_W'(accept) - CNT_W'(pop);
    afull_d    = (occ_q >= OCC_AFULL);
    error_d    = error_q | overflow | (rq_vld_in && !rd_ok) |
                 (ld_write_en_in && !ld_ok);
  end

  // Pipeline and control registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_null_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      occ_q      <= '0;
      afull_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_null_q  <= s1_null_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      occ_q      <= occ_d;
      afull_q    <= afull_d;
      error_q    <= error_d;
    end
  end

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid_q),
    .push_data (s2_data_q),
    .pop       (pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Address bits above the table and FIFO status are intentionally not consumed.
  assign unused_status = ^{rd_info.index[INDEX_BITS-1:ADDR_W],
                           ld_info.index[INDEX_BITS-1:ADDR_W],
                           rd_info.range_ok, ld_info.range_ok,
                           fifo_full, fifo_count};

  assign done            = (occ_q == '0);
  assign rq_afull_out    = afull_q;
  assign rs_write_en_out = pop;
  assign rs_data_out     = fifo_empty ? NULL_PTR : fifo_head;
  assign error_out       = error_q;

endmodule

// File: tb/tb_probe_mem_responder.sv
// Self-checking bench for probe_mem_responder: table-driven reads plus
// hand-written sequences for streaming, backpressure, overflow, collision, reset.
`timescale 1ns/1ps
module tb_probe_mem_responder;

  typedef struct {
    logic [47:0] addr;
    logic [63:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    string       name;
  } exp_t;

`ifdef PROBE_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  localparam logic [63:0] W_IDX0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W_IDX1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W_IDX5 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] W_TOP  = 64'hFFFF_0000_FFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic        rq_afull_out;
  logic        rq_vld_in;
  logic [47:0] rq_address_in;
  logic        rs_afull_in;
  logic        rs_write_en_out;
  logic [63:0] rs_data_out;
  logic        ld_write_en_in;
  logic [47:0] ld_address_in;
  logic [63:0] ld_data_in;
  logic        error_out;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle_cnt = 0;
  int   pop_cnt = 0;
  int   last_pop_cycle = 0;
  exp_t exp_q[$];
  vec_t tbl[7];

  probe_mem_responder dut (
    .clk             (clk),
    .rst             (rst),
    .done            (done),
    .rq_afull_out    (rq_afull_out),
    .rq_vld_in       (rq_vld_in),
    .rq_address_in   (rq_address_in),
    .rs_afull_in     (rs_afull_in),
    .rs_write_en_out (rs_write_en_out),
    .rs_data_out     (rs_data_out),
    .ld_write_en_in  (ld_write_en_in),
    .ld_address_in   (ld_address_in),
    .ld_data_in      (ld_data_in),
    .error_out       (error_out)
  );

  // Free-running clock and cycle counter used for latency measurements.
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [47:0] addr,
                               input logic ld_en, input logic [47:0] ld_addr,
                               input logic [63:0] ld_data);
    @(posedge clk);
    #1;
    rq_vld_in      = vld;
    rq_address_in  = addr;
    ld_write_en_in = ld_en;
    ld_address_in  = ld_addr;
    ld_data_in     = ld_data;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic loadWord(input int idx, input logic [63:0] data);
    applyStimulus(1'b0, '0, 1'b1, 48'(idx) << 3, data);
  endtask

  task automatic issueRead(input logic [47:0] addr, input logic [63:0] exp,
                           input string name);
    exp_t e;
    applyStimulus(1'b1, addr, 1'b0, '0, '0);
    e.data = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (!(done === 1'b1 && exp_q.size() == 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_done"}, 64'(done), 64'h1);
    checkOutput({name, "_outstanding"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    rq_vld_in      = 1'b0;
    ld_write_en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [63:0] streamWord(input int i);
    return {32'hC0DE_5EED, 32'(i)};
  endfunction

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rs_write_en_out === 1'b1) begin
      pop_cnt        = pop_cnt + 1;
      last_pop_cycle = cycle_cnt;
      checkOutput("rs_afull_respected", 64'(rs_afull_in), 64'h0);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_response: got %h, expected no response",
                 rs_data_out);
      end else begin
        e = exp_q.pop_front();
        checkOutput(e.name, rs_data_out, e.data);
      end
    end
  end

  // Main test sequence.
  initial begin
    int issue_cycle;
    int pop_base;
    int afull_hits;
    int issued;

    tbl[0] = '{48'h0000_0000_0000, W_IDX0, "tbl_idx0"};
    tbl[1] = '{48'h0000_0000_0008, W_IDX1, "tbl_idx1"};
    tbl[2] = '{48'h0000_0000_7FF8, W_TOP, "tbl_idx_top"};
    tbl[3] = '{48'h0000_0000_0028, W_IDX5, "tbl_idx5"};
    tbl[4] = '{48'h0000_0000_8008, BOUNDS ? 64'h0 : W_IDX1, "tbl_upper_bit15"};
    tbl[5] = '{48'h0000_0000_002F, BOUNDS ? 64'h0 : W_IDX5, "tbl_low_bits"};
    tbl[6] = '{48'h0100_0000_0000, BOUNDS ? 64'h0 : W_IDX0, "tbl_addr_1_shl_40"};

    rst            = 1'b1;
    rq_vld_in      = 1'b0;
    rq_address_in  = '0;
    rs_afull_in    = 1'b0;
    ld_write_en_in = 1'b0;
    ld_address_in  = '0;
    ld_data_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_done", 64'(done), 64'h1);
    checkOutput("reset_rq_afull", 64'(rq_afull_out), 64'h0);
    checkOutput("reset_rs_write_en", 64'(rs_write_en_out), 64'h0);
    checkOutput("reset_rs_data", rs_data_out, 64'h0);
    checkOutput("reset_error", 64'(error_out), 64'h0);

    // Single read with latency measurement.
    loadWord(5, W_IDX5);
    pop_base = pop_cnt;
    issueRead(48'h28, W_IDX5, "single_read");
    issue_cycle = cycle_cnt;
    idle();
    waitDrain("single");
    checkOutput("single_count", 64'(pop_cnt - pop_base), 64'd1);
    checkOutput("single_latency", 64'(last_pop_cycle - issue_cycle), 64'd3);

    // Table-driven reads, issued back to back.
    loadWord(0, W_IDX0);
    loadWord(1, W_IDX1);
    loadWord(4095, W_TOP);
    for (int i = 0; i < 7; i++) issueRead(tbl[i].addr, tbl[i].exp, tbl[i].name);
    idle();
    waitDrain("table");
    checkOutput("table_error", 64'(error_out), 64'(BOUNDS));
    doReset();
    checkOutput("error_cleared_by_reset", 64'(error_out), 64'h0);

    // Back-to-back stream of 100 reads.
    for (int i = 0; i < 100; i++) loadWord(i, streamWord(i));
    pop_base   = pop_cnt;
    afull_hits = 0;
    issue_cycle = 0;
    for (int i = 0; i < 100; i++) begin
      issueRead(48'(i) << 3, streamWord(i), "stream_data");
      if (i == 0) issue_cycle = cycle_cnt;
      if (rq_afull_out === 1'b1) afull_hits++;
    end
    idle();
    waitDrain("stream");
    checkOutput("stream_count", 64'(pop_cnt - pop_base), 64'd100);
    checkOutput("stream_span", 64'(last_pop_cycle - issue_cycle), 64'd102);
    checkOutput("stream_afull_hits", 64'(afull_hits), 64'd0);

    // Backpressure: issue until afull, which rises one cycle after occupancy 12.
    rs_afull_in = 1'b1;
    pop_base    = pop_cnt;
    issued      = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (rq_afull_out === 1'b1) break;
      rq_vld_in     = 1'b1;
      rq_address_in = 48'(j + 20) << 3;
      exp_q.push_back('{streamWord(j + 20), "bp_data"});
      issued++;
    end
    rq_vld_in = 1'b0;
    checkOutput("bp_issued_until_afull", 64'(issued), 64'd13);
    checkOutput("bp_done_low", 64'(done), 64'h0);
    repeat (4) idle();
    checkOutput("bp_no_pops_held", 64'(pop_cnt - pop_base), 64'd0);
    rs_afull_in = 1'b0;
    waitDrain("bp");
    checkOutput("bp_count", 64'(pop_cnt - pop_base), 64'd13);
    checkOutput("bp_error", 64'(error_out), 64'h0);
    checkOutput("bp_afull_released", 64'(rq_afull_out), 64'h0);

    // Overflow: 17 requests while responses are blocked; the 17th is dropped.
    rs_afull_in = 1'b1;
    pop_base    = pop_cnt;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 48'(i) << 3, 1'b0, '0, '0);
      if (i < 16) exp_q.push_back('{streamWord(i), "ovf_data"});
    end
    idle();
    repeat (2) idle();
    checkOutput("ovf_error", 64'(error_out), 64'h1);
    checkOutput("ovf_afull", 64'(rq_afull_out), 64'h1);
    rs_afull_in = 1'b0;
    waitDrain("ovf");
    checkOutput("ovf_count", 64'(pop_cnt - pop_base), 64'd16);
    checkOutput("ovf_error_sticky", 64'(error_out), 64'h1);

    // Reset with five requests in flight: nothing comes back.
    rs_afull_in = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 48'(i) << 3, 1'b0, '0, '0);
    idle();
    checkOutput("rstmid_done_low", 64'(done), 64'h0);
    doReset();
    pop_base    = pop_cnt;
    rs_afull_in = 1'b0;
    repeat (10) idle();
    checkOutput("rstmid_no_responses", 64'(pop_cnt - pop_base), 64'd0);
    checkOutput("rstmid_done", 64'(done), 64'h1);
    checkOutput("rstmid_error", 64'(error_out), 64'h0);

    // Read/load collision on index 7: same cycle sees old data, next sees new.
    loadWord(7, 64'h9);
    applyStimulus(1'b1, 48'h38, 1'b1, 48'h38, 64'h1);
    exp_q.push_back('{64'h9, "collision_same_cycle"});
    issueRead(48'h38, 64'h1, "collision_next_cycle");
    idle();
    waitDrain("collision");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
